// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore datapath controls decoded from state, pc_en combinational.
// Latency: one state per clock; lw 5, sw/R/addi 4, beq/j/bne 3, unknown opcode 2 cycles.
// No backpressure; optional bne support is compiled in with MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q, state_d;
    logic [3:0] funct_alu;
    logic       pc_write, branch, branch_ne;
    logic       ir_write_s, reg_write_s, mem_write_s;

    // R-type function field to ALU operation; unsupported functs fall back to add.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    // State register; reset parks the FSM in FETCH at any point of an instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore control decode; anything not set for a state stays at its default.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNE: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch_ne   = 1'b1;
            end
`endif
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are held off combinationally while reset is asserted,
    // since FETCH (the reset state) would otherwise raise ir_write and pc_en.
    assign ir_write  = ir_write_s  & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign pc_en     = rst_n & (pc_write | (branch & zero) | (branch_ne & ~zero));
    assign state     = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous active-low reset `rst_n`.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26] from IR.
REQ-005 funct  input  6  instruction bits [5:0] from IR.
REQ-006 zero  input  1  ALU zero flag, same cycle as the ALU result.
REQ-007 alu_control  output  4  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-008 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  00 = register B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-011 pc_en  output  1  PC load enable.
REQ-012 ir_write, reg_write, mem_write, iord, reg_dst, mem_to_reg  output  1 each  standard multicycle datapath strobes and selects.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 The FSM SHALL have the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11 and BNE=12, and registers the state on the rising edge of `clk`.
REQ-015 Transitions SHALL be as follows:
- FETCH goes to DECODE.
- DECODE goes, by opcode: lw 100011 / sw 101011 to MEMADR; 000000 to EXEC; 000100 to BEQ; 001000 to ADDIEX; 000010 to JUMP; any other opcode to FETCH.
- MEMADR goes to MEMRD for lw and to MEMWR for sw.
- MEMRD goes to MEMWB.
- EXEC goes to ALUWB; ADDIEX goes to ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, BNE and JUMP go to FETCH.
REQ-016 The outputs SHALL be Moore outputs decoded from state, except `pc_en`.
- Unlisted outputs are 0.
- alu_control is 0010 unless stated otherwise.
REQ-017 FETCH SHALL drive ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, pc_src=00, iord=0.
REQ-018 DECODE SHALL drive alu_src_a=0, alu_src_b=11; MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10.
REQ-019 MEMRD SHALL drive iord=1; MEMWR SHALL drive iord=1, mem_write=1; MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-020 EXEC SHALL drive alu_src_a=1, alu_src_b=00, with alu_control decoded from funct:
- 100000 gives 0010; 100010 gives 0110; 100100 gives 0000; 100101 gives 0001; 101010 gives 0111.
- Any other funct gives 0010.
REQ-021 ALUWB SHALL drive reg_write=1, reg_dst=1; ADDIWB SHALL drive reg_write=1, reg_dst=0.
REQ-022 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_control=0110, pc_src=01, branch=1; JUMP SHALL drive pc_src=10, pc_write=1.
REQ-023 `pc_en` SHALL equal pc_write OR (branch AND zero) OR (branch_ne AND NOT zero), evaluated combinationally in the same cycle.
REQ-024 The cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bne 3, unknown opcode 2.

Reset
REQ-025 Asserting `rst_n` low SHALL force state to FETCH asynchronously, at any point including mid-instruction.
REQ-026 While `rst_n` is low, ir_write, pc_en, reg_write and mem_write SHALL be 0.
REQ-027 The first rising edge after `rst_n` deasserts SHALL execute FETCH.

Configuration
REQ-028 With macro `MIPS_CTRL_BNE_EN` defined, the BNE state SHALL be present:
- DECODE goes to BNE on opcode 000101.
- BNE drives outputs as BEQ, but with branch_ne=1 in place of branch=1.
REQ-029 Without `MIPS_CTRL_BNE_EN`, opcode 000101 SHALL be treated as unknown (DECODE goes to FETCH), and branch_ne SHALL be tied to 0.

Verification
REQ-030 Reset scenario: rst_n low mid-MEMRD -> state=0 immediately and all write strobes 0; after release, FETCH shows ir_write=1 and pc_en=1.
REQ-031 lw scenario: opcode 100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-032 R-type scenario: opcode 000000 with funct 100010 -> alu_control=0110 in EXEC; with funct 101010 -> 0111; reg_dst=1 in ALUWB.
REQ-033 beq scenario: opcode 000100 -> in state 8, zero=1 gives pc_en=1 and zero=0 gives pc_en=0; state returns to 0 the next cycle.
REQ-034 bne/unknown scenario: opcode 000101 -> with the macro, state 12 and pc_en=1 when zero=0; without the macro, DECODE goes to FETCH. Opcode 111111 -> DECODE goes to FETCH.
REQ-035 sw/j scenario: opcode 101011 -> sequence 0,1,2,5,0 with mem_write=1 only in state 5; opcode 000010 -> pc_src=10 and pc_en=1 in state 11.
